// File: rtl/ram_dp_sweep.sv
// ram_dp_sweep: simple dual-port RAM with a two-edge registered read,
// optional write-to-read forwarding and a built-in constant-fill sweep.
// Ports: clock, reset_n (synchronous, active-low);
//   wr_en/wr_addr/data_in  write port (signed data);
//   rd_en/rd_addr          read request;
//   data_out/rd_valid      registered read data and one-cycle strobe;
//   clr_req                level-sampled sweep request;
//   ready                  high while reads and writes are accepted.
module ram_dp_sweep #(
   parameter int unsigned       DATA_W         = 8,
   parameter int unsigned       ADDR_W         = 10,
   parameter int unsigned       DEPTH          = 1024,
   parameter bit                CLEAR_ON_RESET = 1'b1,
   parameter logic [DATA_W-1:0] CLEAR_VAL      = '0,
   parameter bit                BYPASS         = 1'b1
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic signed [DATA_W-1:0] data_in,
   input  logic                     rd_en,
   input  logic [ADDR_W-1:0]        rd_addr,
   output logic signed [DATA_W-1:0] data_out,
   output logic                     rd_valid,
   input  logic                     clr_req,
   output logic                     ready
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      INIT,
      CLEAR,
      READY
   } state_t;

   logic [DATA_W-1:0] mem [DEPTH];

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              ready_q, ready_d;
   logic              rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              rd_en_q, rd_en_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

   logic              mem_we;
   logic [IDX_W-1:0]  mem_idx;
   logic [DATA_W-1:0] mem_wdata;
   logic              wr_ok;
   logic              rd_ok;

   // Out-of-range decode only exists when the address space is larger
   // than the array.
   if (64'(DEPTH) < (64'd1 << ADDR_W)) begin : g_rng
      assign wr_ok = wr_addr < ADDR_W'(DEPTH);
      assign rd_ok = rd_addr_q < ADDR_W'(DEPTH);
   end else begin : g_full
      assign wr_ok = 1'b1;
      assign rd_ok = 1'b1;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ready_d    = ready_q;
      rd_valid_d = 1'b0;
      data_out_d = data_out_q;
      rd_en_d    = 1'b0;
      rd_addr_d  = rd_addr_q;
      mem_we     = 1'b0;
      mem_idx    = wr_addr[IDX_W-1:0];
      mem_wdata  = data_in;
      unique case (state_q)
         INIT: begin
            if (CLEAR_ON_RESET) begin
               state_d = CLEAR;
            end else begin
               state_d = READY;
               ready_d = 1'b1;
            end
         end
         CLEAR: begin
            mem_we    = 1'b1;
            mem_idx   = cnt_q[IDX_W-1:0];
            mem_wdata = CLEAR_VAL;
            if (cnt_q == LAST) begin
               state_d = READY;
               ready_d = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         READY: begin
            mem_we  = wr_en && wr_ok;
            rd_en_d = rd_en;
            if (rd_en) begin
               rd_addr_d = rd_addr;
            end
            if (rd_en_q) begin
               rd_valid_d = 1'b1;
               if (!rd_ok) begin
                  data_out_d = CLEAR_VAL;
               end else if (BYPASS && wr_en && wr_addr == rd_addr_q) begin
                  data_out_d = data_in;
               end else begin
                  // Old word: the memory write lands on this same edge.
                  data_out_d = mem[rd_addr_q[IDX_W-1:0]];
               end
            end
            if (clr_req) begin
               state_d = CLEAR;
               ready_d = 1'b0;
            end
         end
         default: begin
            state_d = INIT;
            ready_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q    <= INIT;
         cnt_q      <= '0;
         ready_q    <= 1'b0;
         rd_valid_q <= 1'b0;
         data_out_q <= '0;
         rd_en_q    <= 1'b0;
         rd_addr_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ready_q    <= ready_d;
         rd_valid_q <= rd_valid_d;
         data_out_q <= data_out_d;
         rd_en_q    <= rd_en_d;
         rd_addr_q  <= rd_addr_d;
      end
   end

   // Contents survive reset; a sweep cut short by reset writes nothing
   // on the reset edge itself.
   always_ff @(posedge clock) begin
      if (reset_n && mem_we) begin
         mem[mem_idx] <= mem_wdata;
      end
   end

   assign data_out = data_out_q;
   assign rd_valid = rd_valid_q;
   assign ready    = ready_q;

endmodule

// File: tb/tb_ram_dp_sweep.sv
// tb_ram_dp_sweep: two ram_dp_sweep instances (forwarding + clear on reset,
// and no forwarding + no clear) driven together, checked by a scoreboard.
module tb_ram_dp_sweep;

   localparam int DW  = 8;
   localparam int AW  = 5;
   localparam int DEP = 16;
   localparam logic [7:0] CV0 = 8'hFD;
   localparam logic [7:0] CV1 = 8'h5A;

   logic                 clock   = 1'b0;
   logic                 reset_n = 1'b0;
   logic                 wr_en   = 1'b0;
   logic [AW-1:0]        wr_addr = '0;
   logic signed [DW-1:0] data_in = '0;
   logic                 rd_en   = 1'b0;
   logic [AW-1:0]        rd_addr = '0;
   logic                 clr_req = 1'b0;

   logic signed [DW-1:0] dout0, dout1;
   logic                 vld0, vld1, rdy0, rdy1;

   always #5 clock = ~clock;

   ram_dp_sweep #(
      .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP),
      .CLEAR_ON_RESET(1'b1), .CLEAR_VAL(CV0), .BYPASS(1'b1)
   ) u_dut0 (
      .clock(clock), .reset_n(reset_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .data_in(data_in),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .data_out(dout0), .rd_valid(vld0),
      .clr_req(clr_req), .ready(rdy0)
   );

   ram_dp_sweep #(
      .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP),
      .CLEAR_ON_RESET(1'b0), .CLEAR_VAL(CV1), .BYPASS(1'b0)
   ) u_dut1 (
      .clock(clock), .reset_n(reset_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .data_in(data_in),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .data_out(dout1), .rd_valid(vld1),
      .clr_req(clr_req), .ready(rdy1)
   );

   typedef struct {
      logic [7:0] d;
      bit         dc;
      int         due;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   int cyc   = 0;
   int total = 0;
   int bad   = 0;
   bit done  = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   // Reference model: word array with known flags, a busy countdown of
   // non-ready edges and one outstanding read per instance.
   logic [7:0]    mm [2][32];
   bit            mk [2][32];
   bit            m_ready [2];
   int            m_busy [2];
   bit            m_sweep [2];
   bit            m_pend [2];
   logic [AW-1:0] m_paddr [2];
   bit            m_rst [2];

   task automatic push(input int k, input exp_t e);
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic model_edge(input int k);
      exp_t       e;
      logic [7:0] cv;
      bit         cor;
      bit         byp;
      cv  = (k == 0) ? CV0 : CV1;
      cor = (k == 0);
      byp = (k == 0);
      m_rst[k] = 1'b0;
      if (!reset_n) begin
         m_rst[k] = 1'b1;
         if (m_sweep[k] && !cor) begin
            for (int i = 0; i < 32; i++) mk[k][i] = 1'b0;
         end
         m_ready[k] = 1'b0;
         m_pend[k]  = 1'b0;
         m_sweep[k] = cor;
         m_busy[k]  = cor ? DEP + 1 : 1;
         return;
      end
      if (m_pend[k] && m_ready[k]) begin
         e.due = cyc + 1;
         e.dc  = 1'b0;
         if (int'(m_paddr[k]) >= DEP) begin
            e.d = cv;
         end else if (byp && wr_en && wr_addr == m_paddr[k]) begin
            e.d = data_in;
         end else begin
            e.d  = mm[k][m_paddr[k]];
            e.dc = !mk[k][m_paddr[k]];
         end
         push(k, e);
      end
      m_pend[k] = 1'b0;
      if (m_ready[k]) begin
         if (rd_en) begin
            m_pend[k]  = 1'b1;
            m_paddr[k] = rd_addr;
         end
         if (wr_en && int'(wr_addr) < DEP) begin
            mm[k][wr_addr] = data_in;
            mk[k][wr_addr] = 1'b1;
         end
         if (clr_req) begin
            m_ready[k] = 1'b0;
            m_sweep[k] = 1'b1;
            m_busy[k]  = DEP;
         end
      end else begin
         m_busy[k] = m_busy[k] - 1;
         if (m_busy[k] == 0) begin
            m_ready[k] = 1'b1;
            if (m_sweep[k]) begin
               for (int i = 0; i < DEP; i++) begin
                  mm[k][i] = cv;
                  mk[k][i] = 1'b1;
               end
            end
            m_sweep[k] = 1'b0;
         end
      end
   endtask

   task automatic cyc_do(input bit r, input bit w, input logic [AW-1:0] a,
                         input logic [7:0] d, input bit rr,
                         input logic [AW-1:0] ra, input bit c);
      @(negedge clock);
      reset_n = r;
      wr_en   = w;
      wr_addr = a;
      data_in = d;
      rd_en   = rr;
      rd_addr = ra;
      clr_req = c;
      model_edge(0);
      model_edge(1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc_do(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
   endtask

   task automatic rnd_cyc(input bit allow_clr, input bit allow_rst);
      bit r;
      bit c;
      r = !(allow_rst && $urandom_range(0, 99) == 0);
      c = allow_clr && ($urandom_range(0, 39) == 0);
      cyc_do(r, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 19)),
             8'($urandom), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 19)), c);
   endtask

   task automatic check(input string nm, input int k,
                        input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s inst%0d cyc=%0d: got %0h want %0h",
                  nm, k, cyc, got, want);
      end
   endtask

   task automatic chk_inst(input int k, input logic rdy, input logic vld,
                           input logic [7:0] dout);
      exp_t e;
      bit   ev;
      ev = 1'b0;
      if (k == 0 && q0.size() > 0 && q0[0].due == cyc) begin
         e  = q0.pop_front();
         ev = 1'b1;
      end
      if (k == 1 && q1.size() > 0 && q1[0].due == cyc) begin
         e  = q1.pop_front();
         ev = 1'b1;
      end
      check("ready", k, 32'(rdy), 32'(m_ready[k]));
      check("rd_valid", k, 32'(vld), 32'(ev));
      if (ev && !e.dc) check("data_out", k, 32'(dout), 32'(e.d));
      if (m_rst[k]) check("rst_data_out", k, 32'(dout), 32'd0);
   endtask

   always @(posedge clock) begin
      #1;
      chk_inst(0, rdy0, vld0, dout0);
      chk_inst(1, rdy1, vld1, dout1);
      if (done) begin
         check("q_empty", 0, 32'(q0.size()), 32'd0);
         check("q_empty", 1, 32'(q1.size()), 32'd0);
         $display("test done: total=%0d bad=%0d", total, bad);
         $finish;
      end
   end

   initial begin
      cyc_do(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
      cyc_do(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
      // traffic during the power-up sweep of inst0
      for (int i = 0; i < 20; i++) rnd_cyc(1'b0, 1'b0);
      idle(2);
      for (int i = 0; i < DEP; i++) begin
         cyc_do(1'b1, 1'b0, '0, '0, 1'b1, 5'(i), 1'b0);
      end
      idle(3);
      // fill inst1 so later reads are known
      for (int i = 0; i < DEP; i++) begin
         cyc_do(1'b1, 1'b1, 5'(i), 8'(i * 7 + 1), 1'b0, '0, 1'b0);
      end
      cyc_do(1'b1, 1'b1, 5'd5, 8'd100, 1'b0, '0, 1'b0);
      cyc_do(1'b1, 1'b0, '0, '0, 1'b1, 5'd5, 1'b0);
      idle(3);
      // collision: read at 7 holding 11, write 42 on the following edge
      cyc_do(1'b1, 1'b1, 5'd7, 8'd11, 1'b0, '0, 1'b0);
      cyc_do(1'b1, 1'b0, '0, '0, 1'b1, 5'd7, 1'b0);
      cyc_do(1'b1, 1'b1, 5'd7, 8'd42, 1'b0, '0, 1'b0);
      cyc_do(1'b1, 1'b0, '0, '0, 1'b1, 5'd7, 1'b0);
      idle(3);
      // sweep request together with a read and a write
      cyc_do(1'b1, 1'b1, 5'd3, 8'h77, 1'b1, 5'd3, 1'b1);
      for (int i = 0; i < 18; i++) rnd_cyc(1'b1, 1'b0);
      idle(2);
      for (int i = 0; i < DEP; i++) begin
         cyc_do(1'b1, 1'b0, '0, '0, 1'b1, 5'(i), 1'b0);
      end
      idle(2);
      // out-of-range write dropped, reads return CLEAR_VAL
      cyc_do(1'b1, 1'b1, 5'd20, 8'h33, 1'b0, '0, 1'b0);
      cyc_do(1'b1, 1'b0, '0, '0, 1'b1, 5'd20, 1'b0);
      cyc_do(1'b1, 1'b0, '0, '0, 1'b1, 5'd31, 1'b0);
      idle(3);
      // reset while the sweep is at address 9
      cyc_do(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1);
      idle(9);
      cyc_do(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
      for (int i = 0; i < 20; i++) rnd_cyc(1'b0, 1'b0);
      // most negative value passes through unchanged
      cyc_do(1'b1, 1'b1, 5'd0, 8'h80, 1'b0, '0, 1'b0);
      cyc_do(1'b1, 1'b0, '0, '0, 1'b1, 5'd0, 1'b0);
      idle(3);
      for (int i = 0; i < 400; i++) rnd_cyc(1'b1, 1'b1);
      idle(4);
      done = 1'b1;
      repeat (5) @(posedge clock);
      $display("FAIL watchdog: summary not reached");
      $fatal(1, "watchdog");
   end

endmodule
